rob_retire_ctrl: RTL and testbench
==================================

Name: rob_retire_ctrl

Overview:
- Sits directly downstream of the row/unique-ID assignment stage in the ROB.
- Records each allocated row (unique_id plus original AXI ID) in allocation order and marks rows complete when their response's last beat has been stored.
- Retires rows strictly in allocation order through a valid/ready release port.
- The released uid is returned to the assignment stage, which marks that row available again.

Parameters:
ID_WIDTH, 4, AXI ID width (original ID carried with each row)
MAX_OUTSTANDING, 16, number of rows and order-queue depth; power of two, >= 2
UID_WIDTH, $clog2(MAX_OUTSTANDING), row index width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
alloc_valid  input  1  assignment stage has allocated a row this cycle
alloc_ready  output  1  order queue can accept an allocation
alloc_uid  input  UID_WIDTH  allocated row index
alloc_id  input  ID_WIDTH  original AXI ID of the allocated row
cpl_valid  input  1  last response beat for cpl_uid stored in ROB (single-cycle pulse)
cpl_uid  input  UID_WIDTH  completed row index
rel_valid  output  1  head row is complete and ready to retire
rel_ready  input  1  consumer accepts the release
rel_uid  output  UID_WIDTH  row index being retired (freed back to the assignment stage)
rel_id  output  ID_WIDTH  original AXI ID of the retired row
occupancy  output  UID_WIDTH+1  rows currently outstanding
err_alloc  output  1  sticky: allocation of a row already in use
err_cpl  output  1  sticky: completion for a row not in use, or already completed

Behaviour:
- State:
  - Circular order queue of MAX_OUTSTANDING entries {uid, id}.
  - wr_ptr and rd_ptr, each UID_WIDTH+1 bits; the MSB is the wrap bit.
  - in_use[MAX_OUTSTANDING] and done[MAX_OUTSTANDING] bit vectors.
- Reset (async assert, any cycle):
  - Pointers = 0; in_use = 0; done = 0.
  - alloc_ready = 1, rel_valid = 0, rel_uid = 0, rel_id = 0, occupancy = 0, err_alloc = 0, err_cpl = 0.
  - Queue storage need not be cleared.
  - Reset mid-operation discards every outstanding row.
- full = (ptr LSBs equal and wrap bits differ). empty = (pointers equal). occupancy = wr_ptr - rd_ptr, modulo 2^(UID_WIDTH+1).
- Allocation:
  - alloc_ready = !full, registered-state only; no bypass from a same-cycle release.
  - On alloc_valid && alloc_ready: write {alloc_uid, alloc_id} at wr_ptr, increment wr_ptr, set in_use[alloc_uid], clear done[alloc_uid].
  - If in_use[alloc_uid] is already 1: set err_alloc and still perform the push.
  - alloc_valid while full: ignored, no state change.
- Completion:
  - On cpl_valid: if in_use[cpl_uid] && !done[cpl_uid], set done[cpl_uid]; otherwise set err_cpl and change no other state.
  - Completions may arrive in any order.
- Release:
  - rel_valid = !empty && done[head.uid], driven from registers.
  - Latency: completion of the head row in cycle N gives rel_valid = 1 in cycle N+1.
  - rel_uid and rel_id show the head entry whenever !empty; they are 0 when empty.
  - On rel_valid && rel_ready: increment rd_ptr, clear in_use and done for that uid.
  - rel_valid/rel_uid/rel_id must hold stable while rel_ready = 0.
  - Non-head completed rows wait, regardless of how long.
- Simultaneous events in one cycle:
  - Alloc push + release pop: both take effect; occupancy unchanged.
  - Alloc of uid X + release of uid X: the release clears and the alloc sets, so in_use[X] = 1 and done[X] = 0 afterwards, with no err_alloc.
  - Completion of uid Y + release of a different uid: both take effect.
- Wrap-around: pointers wrap naturally modulo 2^(UID_WIDTH+1); the order queue index uses the LSBs.
- Errors are sticky until reset.

Optional Feature:
- Macro: ROB_RETIRE_STATS_EN.
- Defined: adds outputs stall_cnt (16 bits) and max_occ (UID_WIDTH+1 bits).
  - stall_cnt increments each cycle with rel_valid && !rel_ready, saturating at 16'hFFFF.
  - max_occ holds the peak occupancy since reset.
  - Both reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then alloc uids 3,7,1 with ids 2,5,9; complete 1 then 7 -> no rel_valid; complete 3 -> the next cycles release (3,2), (7,5), (1,9) in that order with rel_ready = 1.
- Allocate 16 rows with no completions -> occupancy = 16, alloc_ready = 0; an extra alloc_valid is ignored; complete and release the head -> alloc_ready = 1 the next cycle.
- Head completed, rel_ready held 0 for 5 cycles -> rel_valid and rel_uid stable; with ROB_RETIRE_STATS_EN, stall_cnt = 5.
- cpl_valid for a never-allocated uid 4 -> err_cpl = 1, sticky; completing an already-done uid also sets it; no release occurs.
- Full queue, head done, rel_ready = 1 and alloc_valid in the same cycle -> pop only, occupancy 15; next cycle an alloc of the just-freed uid is accepted with err_alloc = 0.
- Assert rst mid-burst with 6 rows outstanding -> immediately occupancy = 0, rel_valid = 0; a fresh alloc/complete/release of uid 0 works.

Source files
------------

// File: rtl/rob_retire_ctrl.sv
// ROB retire controller: tracks allocated rows in allocation order and retires completed rows in that order.
// Optional ROB_RETIRE_STATS_EN adds stall_cnt and max_occ statistics outputs.
module rob_retire_ctrl #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int UID_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [UID_WIDTH-1:0] alloc_uid,
  input  logic [ID_WIDTH-1:0]  alloc_id,
  input  logic                 cpl_valid,
  input  logic [UID_WIDTH-1:0] cpl_uid,
  output logic                 rel_valid,
  input  logic                 rel_ready,
  output logic [UID_WIDTH-1:0] rel_uid,
  output logic [ID_WIDTH-1:0]  rel_id,
  output logic [UID_WIDTH:0]   occupancy,
  output logic                 err_alloc,
  output logic                 err_cpl
`ifdef ROB_RETIRE_STATS_EN
  ,
  output logic [15:0]          stall_cnt,
  output logic [UID_WIDTH:0]   max_occ
`endif
);

  localparam logic [UID_WIDTH:0] PTR_ONE = (UID_WIDTH+1)'(1);

  logic [UID_WIDTH:0]         wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] in_use, done;
  logic [MAX_OUTSTANDING-1:0] in_use_nxt, done_nxt;
  logic [UID_WIDTH-1:0]       q_uid [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]        q_id  [MAX_OUTSTANDING];
  logic                       full, empty, push, pop;
  logic [UID_WIDTH-1:0]       head_uid;
  logic [ID_WIDTH-1:0]        head_id;
  logic                       alloc_clash, cpl_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[UID_WIDTH-1:0] == rd_ptr[UID_WIDTH-1:0]) &&
                    (wr_ptr[UID_WIDTH] != rd_ptr[UID_WIDTH]);
  assign head_uid = q_uid[rd_ptr[UID_WIDTH-1:0]];
  assign head_id  = q_id[rd_ptr[UID_WIDTH-1:0]];

  assign alloc_ready = !full;
  assign rel_valid   = !empty && done[head_uid];
  assign rel_uid     = empty ? '0 : head_uid;
  assign rel_id      = empty ? '0 : head_id;
  assign occupancy   = wr_ptr - rd_ptr;

  assign push = alloc_valid && !full;
  assign pop  = rel_valid && rel_ready;

  // A row being retired this cycle may be reallocated in the same cycle without error.
  assign alloc_clash = in_use[alloc_uid] && !(pop && (head_uid == alloc_uid));
  assign cpl_ok      = in_use[cpl_uid] && !done[cpl_uid];

  always_comb begin
    in_use_nxt = in_use;
    done_nxt   = done;
    if (pop) begin
      in_use_nxt[head_uid] = 1'b0;
      done_nxt[head_uid]   = 1'b0;
    end
    if (cpl_valid && cpl_ok)
      done_nxt[cpl_uid] = 1'b1;
    if (push) begin
      in_use_nxt[alloc_uid] = 1'b1;
      done_nxt[alloc_uid]   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_use    <= '0;
      done      <= '0;
      err_alloc <= 1'b0;
      err_cpl   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      in_use    <= in_use_nxt;
      done      <= done_nxt;
      err_alloc <= err_alloc | (push && alloc_clash);
      err_cpl   <= err_cpl | (cpl_valid && !cpl_ok);
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_uid[wr_ptr[UID_WIDTH-1:0]] <= alloc_uid;
      q_id[wr_ptr[UID_WIDTH-1:0]]  <= alloc_id;
    end
  end

`ifdef ROB_RETIRE_STATS_EN
  logic [UID_WIDTH:0] occ_nxt;

  assign occ_nxt = (wr_ptr + (push ? PTR_ONE : '0)) - (rd_ptr + (pop ? PTR_ONE : '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      max_occ   <= '0;
    end else begin
      if (rel_valid && !rel_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (occ_nxt > max_occ)
        max_occ <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Self-checking bench for rob_retire_ctrl: expected releases are queued at allocation and compared on retirement.
module tb_rob_retire_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0;
  logic       alloc_ready;
  logic [3:0] alloc_uid = '0;
  logic [3:0] alloc_id = '0;
  logic       cpl_valid = 1'b0;
  logic [3:0] cpl_uid = '0;
  logic       rel_valid;
  logic       rel_ready = 1'b0;
  logic [3:0] rel_uid;
  logic [3:0] rel_id;
  logic [4:0] occupancy;
  logic       err_alloc;
  logic       err_cpl;
`ifdef ROB_RETIRE_STATS_EN
  logic [15:0] stall_cnt;
  logic [4:0]  max_occ;
`endif

  typedef struct packed {
    logic [3:0] uid;
    logic [3:0] id;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int   checks = 0;
  int   errors = 0;

  rob_retire_ctrl #(.ID_WIDTH(4), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_uid(alloc_uid), .alloc_id(alloc_id),
    .cpl_valid(cpl_valid), .cpl_uid(cpl_uid),
    .rel_valid(rel_valid), .rel_ready(rel_ready),
    .rel_uid(rel_uid), .rel_id(rel_id),
    .occupancy(occupancy), .err_alloc(err_alloc), .err_cpl(err_cpl)
`ifdef ROB_RETIRE_STATS_EN
    , .stall_cnt(stall_cnt), .max_occ(max_occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0;
    cpl_valid   = 1'b0;
    rel_ready   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
    checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL reset_rel_valid got %0b exp 0", rel_valid); end
    checks++; if ({rel_uid, rel_id} !== 8'h00) begin errors++; $display("FAIL reset_rel_data got %0h exp 00", {rel_uid, rel_id}); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if ({err_alloc, err_cpl} !== 2'b00) begin errors++; $display("FAIL reset_err got %0b exp 00", {err_alloc, err_cpl}); end
`ifdef ROB_RETIRE_STATS_EN
    checks++; if (stall_cnt !== 16'd0 || max_occ !== 5'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stall_cnt, max_occ); end
`endif
  endtask

  task automatic test_order();
    logic [3:0] u [3];
    logic [3:0] d [3];
    u = '{4'd3, 4'd7, 4'd1};
    d = '{4'd2, 4'd5, 4'd9};
    do_reset();
    rel_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_uid = u[i]; alloc_id = d[i];
      sb.push_back('{uid: u[i], id: d[i]});
      tick();
    end
    alloc_valid = 1'b0;
    checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL order_occ got %0d exp 3", occupancy); end
    cpl_valid = 1'b1; cpl_uid = 4'd1; tick();
    checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL order_nonhead1 got %0b exp 0", rel_valid); end
    cpl_uid = 4'd7; tick();
    checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL order_nonhead7 got %0b exp 0", rel_valid); end
    cpl_uid = 4'd3; tick();
    cpl_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rel_valid !== 1'b1) begin errors++; $display("FAIL order_rel_valid%0d got %0b exp 1", k, rel_valid); end
      e = sb.pop_front();
      checks++; if (rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL order_rel%0d got %0d/%0d exp %0d/%0d", k, rel_uid, rel_id, e.uid, e.id); end
      tick();
    end
    checks++; if (occupancy !== 5'd0 || rel_valid !== 1'b0 || {rel_uid, rel_id} !== 8'h00) begin errors++; $display("FAIL order_drain got occ %0d v %0b data %0h exp 0 0 00", occupancy, rel_valid, {rel_uid, rel_id}); end
    checks++; if ({err_alloc, err_cpl} !== 2'b00) begin errors++; $display("FAIL order_err got %0b exp 00", {err_alloc, err_cpl}); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_uid = 4'(i); alloc_id = 4'(15 - i);
      sb.push_back('{uid: 4'(i), id: 4'(15 - i)});
      tick();
    end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ got %0d exp 16", occupancy); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", alloc_ready); end
`ifdef ROB_RETIRE_STATS_EN
    checks++; if (max_occ !== 5'd16) begin errors++; $display("FAIL full_max_occ got %0d exp 16", max_occ); end
`endif
    alloc_uid = 4'd5; alloc_id = 4'hA; tick();
    alloc_valid = 1'b0;
    checks++; if (occupancy !== 5'd16 || err_alloc !== 1'b0) begin errors++; $display("FAIL full_ignore got occ %0d err %0b exp 16 0", occupancy, err_alloc); end
    cpl_valid = 1'b1; cpl_uid = 4'd0; tick();
    cpl_valid = 1'b0;
    checks++; if (rel_valid !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_head_done got v %0b r %0b exp 1 0", rel_valid, alloc_ready); end
    rel_ready = 1'b1;
    e = sb.pop_front();
    checks++; if (rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL full_rel got %0d/%0d exp %0d/%0d", rel_uid, rel_id, e.uid, e.id); end
    tick();
    rel_ready = 1'b0;
    checks++; if (alloc_ready !== 1'b1 || occupancy !== 5'd15) begin errors++; $display("FAIL full_after_pop got r %0b occ %0d exp 1 15", alloc_ready, occupancy); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc_valid = 1'b1; alloc_uid = 4'd2; alloc_id = 4'd6; sb.push_back('{uid: 4'd2, id: 4'd6}); tick();
    alloc_uid = 4'd9; alloc_id = 4'd4; sb.push_back('{uid: 4'd9, id: 4'd4}); tick();
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd2; tick();
    cpl_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rel_valid !== 1'b1 || rel_uid !== 4'd2 || rel_id !== 4'd6) begin errors++; $display("FAIL stall_hold%0d got %0b %0d/%0d exp 1 2/6", k, rel_valid, rel_uid, rel_id); end
      tick();
    end
`ifdef ROB_RETIRE_STATS_EN
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
`endif
    rel_ready = 1'b1;
    e = sb.pop_front();
    checks++; if (rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL stall_rel got %0d/%0d exp %0d/%0d", rel_uid, rel_id, e.uid, e.id); end
    tick();
    rel_ready = 1'b0;
    checks++; if (rel_valid !== 1'b0 || rel_uid !== 4'd9 || rel_id !== 4'd4) begin errors++; $display("FAIL stall_next_head got %0b %0d/%0d exp 0 9/4", rel_valid, rel_uid, rel_id); end
`ifdef ROB_RETIRE_STATS_EN
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt_hold got %0d exp 5", stall_cnt); end
`endif
  endtask

  task automatic test_err_cpl();
    do_reset();
    alloc_valid = 1'b1; alloc_uid = 4'd0; alloc_id = 4'd1; sb.push_back('{uid: 4'd0, id: 4'd1}); tick();
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd4; tick();
    cpl_valid = 1'b0;
    checks++; if (err_cpl !== 1'b1 || rel_valid !== 1'b0) begin errors++; $display("FAIL err_cpl_unused got err %0b v %0b exp 1 0", err_cpl, rel_valid); end
    tick();
    checks++; if (err_cpl !== 1'b1 || occupancy !== 5'd1) begin errors++; $display("FAIL err_cpl_sticky got err %0b occ %0d exp 1 1", err_cpl, occupancy); end
    do_reset();
    alloc_valid = 1'b1; alloc_uid = 4'd0; alloc_id = 4'd1; sb.push_back('{uid: 4'd0, id: 4'd1}); tick();
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd0; tick();
    checks++; if (err_cpl !== 1'b0 || rel_valid !== 1'b1) begin errors++; $display("FAIL err_cpl_first got err %0b v %0b exp 0 1", err_cpl, rel_valid); end
    tick();
    cpl_valid = 1'b0;
    checks++; if (err_cpl !== 1'b1 || rel_valid !== 1'b1 || occupancy !== 5'd1) begin errors++; $display("FAIL err_cpl_double got err %0b v %0b occ %0d exp 1 1 1", err_cpl, rel_valid, occupancy); end
    rel_ready = 1'b1;
    e = sb.pop_front();
    checks++; if (rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL err_cpl_rel got %0d/%0d exp %0d/%0d", rel_uid, rel_id, e.uid, e.id); end
    tick();
    rel_ready = 1'b0;
  endtask

  task automatic test_full_pop_alloc();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_uid = 4'(15 - i); alloc_id = 4'(i);
      sb.push_back('{uid: 4'(15 - i), id: 4'(i)});
      tick();
    end
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd15; tick();
    cpl_valid = 1'b0;
    rel_ready = 1'b1; alloc_valid = 1'b1; alloc_uid = 4'd15; alloc_id = 4'd3;
    e = sb.pop_front();
    checks++; if (rel_valid !== 1'b1 || rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL fpa_rel got %0b %0d/%0d exp 1 %0d/%0d", rel_valid, rel_uid, rel_id, e.uid, e.id); end
    tick();
    rel_ready = 1'b0;
    checks++; if (occupancy !== 5'd15 || alloc_ready !== 1'b1) begin errors++; $display("FAIL fpa_pop_only got occ %0d r %0b exp 15 1", occupancy, alloc_ready); end
    sb.push_back('{uid: 4'd15, id: 4'd3});
    tick();
    alloc_valid = 1'b0;
    checks++; if (occupancy !== 5'd16 || err_alloc !== 1'b0) begin errors++; $display("FAIL fpa_realloc got occ %0d err %0b exp 16 0", occupancy, err_alloc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_valid = 1'b1; alloc_uid = 4'd5; alloc_id = 4'd1; sb.push_back('{uid: 4'd5, id: 4'd1}); tick();
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd5; tick();
    cpl_valid = 1'b0;
    rel_ready = 1'b1; alloc_valid = 1'b1; alloc_uid = 4'd5; alloc_id = 4'd2;
    e = sb.pop_front();
    checks++; if (rel_valid !== 1'b1 || rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL b2b_rel got %0b %0d/%0d exp 1 %0d/%0d", rel_valid, rel_uid, rel_id, e.uid, e.id); end
    sb.push_back('{uid: 4'd5, id: 4'd2});
    tick();
    alloc_valid = 1'b0; rel_ready = 1'b0;
    checks++; if (occupancy !== 5'd1 || err_alloc !== 1'b0 || rel_valid !== 1'b0) begin errors++; $display("FAIL b2b_same_uid got occ %0d err %0b v %0b exp 1 0 0", occupancy, err_alloc, rel_valid); end
    checks++; if (rel_uid !== 4'd5 || rel_id !== 4'd2) begin errors++; $display("FAIL b2b_head got %0d/%0d exp 5/2", rel_uid, rel_id); end
    alloc_valid = 1'b1; alloc_uid = 4'd6; alloc_id = 4'd8; sb.push_back('{uid: 4'd6, id: 4'd8});
    cpl_valid = 1'b1; cpl_uid = 4'd5; tick();
    alloc_valid = 1'b0;
    cpl_uid = 4'd6; rel_ready = 1'b1;
    e = sb.pop_front();
    checks++; if (rel_valid !== 1'b1 || rel_uid !== e.uid || rel_id !== e.id || err_cpl !== 1'b0) begin errors++; $display("FAIL b2b_rel2 got %0b %0d/%0d err %0b exp 1 %0d/%0d 0", rel_valid, rel_uid, rel_id, err_cpl, e.uid, e.id); end
    tick();
    cpl_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (rel_valid !== 1'b1 || rel_uid !== e.uid || rel_id !== e.id || err_cpl !== 1'b0) begin errors++; $display("FAIL b2b_cpl_and_rel got %0b %0d/%0d err %0b exp 1 %0d/%0d 0", rel_valid, rel_uid, rel_id, err_cpl, e.uid, e.id); end
    tick();
    rel_ready = 1'b0;
    checks++; if (occupancy !== 5'd0 || rel_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got occ %0d v %0b exp 0 0", occupancy, rel_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1; alloc_uid = 4'(i); alloc_id = 4'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd0; tick();
    cpl_valid = 1'b0;
    checks++; if (occupancy !== 5'd6 || rel_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got occ %0d v %0b exp 6 1", occupancy, rel_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (occupancy !== 5'd0 || rel_valid !== 1'b0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL mid_async got occ %0d v %0b r %0b exp 0 0 1", occupancy, rel_valid, alloc_ready); end
    tick();
    rst = 1'b0;
    sb.delete();
    alloc_valid = 1'b1; alloc_uid = 4'd0; alloc_id = 4'd7; sb.push_back('{uid: 4'd0, id: 4'd7}); tick();
    alloc_valid = 1'b0;
    cpl_valid = 1'b1; cpl_uid = 4'd0; tick();
    cpl_valid = 1'b0; rel_ready = 1'b1;
    e = sb.pop_front();
    checks++; if (rel_valid !== 1'b1 || rel_uid !== e.uid || rel_id !== e.id) begin errors++; $display("FAIL mid_fresh_rel got %0b %0d/%0d exp 1 %0d/%0d", rel_valid, rel_uid, rel_id, e.uid, e.id); end
    tick();
    rel_ready = 1'b0;
    checks++; if (occupancy !== 5'd0 || {err_alloc, err_cpl} !== 2'b00) begin errors++; $display("FAIL mid_fresh_end got occ %0d err %0b exp 0 00", occupancy, {err_alloc, err_cpl}); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_stall();
    test_err_cpl();
    test_full_pop_alloc();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
